// File: rtl/sample_capture_controller.sv
// Logic-analyzer acquisition front end: probe sync, sample-rate prescaler,
// trigger FSM and shift-pulse generation for the per-channel sample buffers.
module sample_capture_controller #(
  parameter int CHANNEL_COUNT    = 8,
  parameter int SAMPLE_BUFF_SIZE = 640,
  parameter int PRE_TRIG         = 64,
  parameter int DIV_WIDTH        = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CHANNEL_COUNT-1:0]         chan_in,
  input  logic [DIV_WIDTH-1:0]             sample_div,
  input  logic [$clog2(CHANNEL_COUNT)-1:0] trig_chan,
  input  logic [1:0]                       trig_mode,
  input  logic                             arm,
  output logic                             shift,
  output logic [CHANNEL_COUNT-1:0]         s_in,
  output logic                             busy,
  output logic                             triggered,
  output logic                             done
);

  localparam int CW = $clog2(SAMPLE_BUFF_SIZE + 1);
  localparam logic [CW-1:0] PRE_C  = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_N = CW'(SAMPLE_BUFF_SIZE - PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CHANNEL_COUNT-1:0] sync1_q, sync2_q;
  logic [CHANNEL_COUNT-1:0] smp_q, smp_d;
  logic [DIV_WIDTH-1:0]     pcnt_q, pcnt_d;
  logic [CW-1:0]            scnt_q, scnt_d;
  logic                     prev_q, prev_d;
  logic                     pv_q, pv_d;
  logic                     trig_q, trig_d;
  logic                     shift_q, shift_d;

  logic run, last, tick, cur, fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      smp_q   <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
      prev_q  <= 1'b0;
      pv_q    <= 1'b0;
      trig_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= chan_in;
      sync2_q <= sync1_q;
      smp_q   <= smp_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      trig_q  <= trig_d;
      shift_q <= shift_d;
    end
  end

  assign run  = (state_q == S_PRE) || (state_q == S_ARMED)
             || (state_q == S_POST);
  // The cycle carrying the final shift must not start another sample.
  assign last = (state_q == S_POST) && (scnt_q == POST_N);
  assign tick = run && !last && (pcnt_q >= sample_div);
  assign cur  = sync2_q[trig_chan];

  always_comb begin
    fire = 1'b0;
    unique case (trig_mode)
      2'b00:   fire = 1'b1;
      2'b01:   fire = pv_q & ~prev_q & cur;
      2'b10:   fire = pv_q & prev_q & ~cur;
      default: fire = pv_q & (prev_q ^ cur);
    endcase
  end

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    pcnt_d  = '0;
    scnt_d  = scnt_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    trig_d  = trig_q;
    shift_d = 1'b0;

    if (run) pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    if (tick) begin
      shift_d = 1'b1;
      smp_d   = sync2_q;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d = (PRE_TRIG == 0) ? S_ARMED : S_PRE;
          scnt_d  = '0;
          pv_d    = 1'b0;
          trig_d  = 1'b0;
        end
      end
      S_PRE: begin
        if (tick) begin
          scnt_d = scnt_q + 1'b1;
          prev_d = cur;
          pv_d   = 1'b1;
          if (scnt_q + 1'b1 == PRE_C) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (tick) begin
          prev_d = cur;
          pv_d   = 1'b1;
          if (fire) begin
            state_d = S_POST;
            trig_d  = 1'b1;
            scnt_d  = CW'(1);
          end
        end
      end
      S_POST: begin
        if (tick) scnt_d = scnt_q + 1'b1;
        if (last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign shift     = shift_q;
  assign s_in      = smp_q;
  assign busy      = run;
  assign triggered = trig_q;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sample_capture_controller.sv
// Directed bench for sample_capture_controller; acts as the channel
// shift-register consumer and checks pulse timing and captured window.
module tb_sample_capture_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] chan_in = '0;
  logic [15:0] sample_div = '0;
  logic [2:0] trig_chan = '0;
  logic [1:0] trig_mode = '0;
  logic       arm = 1'b0;
  logic       shift;
  logic [7:0] s_in;
  logic       busy;
  logic       triggered;
  logic       done;

  int nchk = 0;
  int nerr = 0;

  int np  = 0;
  int cyc = 0;
  logic [7:0] smp  [0:8191];
  int         pcyc [0:8191];
  logic       trg  [0:8191];

  sample_capture_controller dut (
    .clk       (clk),
    .reset     (reset),
    .chan_in   (chan_in),
    .sample_div(sample_div),
    .trig_chan (trig_chan),
    .trig_mode (trig_mode),
    .arm       (arm),
    .shift     (shift),
    .s_in      (s_in),
    .busy      (busy),
    .triggered (triggered),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Consumer side: every shift pulse appends one sample
  always @(posedge clk) begin
    if (shift) begin
      smp[np[12:0]]  <= s_in;
      pcyc[np[12:0]] <= cyc;
      trg[np[12:0]]  <= triggered;
      np <= np + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 32'(done), 1);
  endtask

  initial begin
    int base, n, st, c, orv;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_shift", 32'(shift), 0);
    chk("rst_s_in", 32'(s_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_trig", 32'(triggered), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    // 1: immediate mode, tick every clk
    chan_in = 8'hA5;
    trig_mode = 2'b00;
    sample_div = 16'd0;
    repeat (4) @(negedge clk);
    base = np;
    pulse_arm();
    chk("t1_busy_after_arm", 32'(busy), 1);
    wait_done(2000);
    chk("t1_pulses", 32'(np - base), 640);
    chk("t1_consecutive", 32'(pcyc[base+639] - pcyc[base]), 639);
    chk("t1_done_cycle", 32'(cyc), 32'(pcyc[base+639] + 1));
    chk("t1_trig_pulse64", 32'(trg[base+63]), 0);
    chk("t1_trig_pulse66", 32'(trg[base+65]), 1);
    chk("t1_buf64", 32'(smp[base+64]), 32'h A5);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_trig_end", 32'(triggered), 1);
    @(negedge clk);
    chk("t1_no_shift_done", 32'(shift), 0);

    // 4: re-arm from DONE, then arm during POST is ignored
    base = np;
    pulse_arm();
    chk("t4_done_clr", 32'(done), 0);
    chk("t4_trig_clr", 32'(triggered), 0);
    chk("t4_busy", 32'(busy), 1);
    repeat (300) @(negedge clk);
    chk("t4_shift_resumed", 32'(np - base > 250), 1);
    pulse_arm();
    wait_done(2000);
    chk("t4_pulses", 32'(np - base), 640);

    // 2: rising edge on ch3, sample every 5 clk
    chan_in = 8'h05;
    trig_mode = 2'b01;
    trig_chan = 3'd3;
    sample_div = 16'd4;
    repeat (4) @(negedge clk);
    base = np;
    pulse_arm();
    repeat (1500) @(negedge clk);
    chan_in = 8'h0D;
    wait_done(8000);
    n = np - base;
    st = base + n - 640;
    chk("t2_enough", 32'(n >= 640), 1);
    orv = 0;
    for (int i = 0; i < 64; i++) orv = orv | int'(smp[st+i][3]);
    chk("t2_pre_all_low", 32'(orv), 0);
    chk("t2_buf63", 32'(smp[st+63]), 32'h05);
    chk("t2_buf64", 32'(smp[st+64]), 32'h0D);
    chk("t2_buf639", 32'(smp[st+639]), 32'h0D);
    chk("t2_period", 32'(pcyc[base+n-1] - pcyc[base+n-2]), 5);
    chk("t2_trig", 32'(triggered), 1);

    // 3: falling mode, ch3 held high: never triggers
    trig_mode = 2'b10;
    base = np;
    pulse_arm();
    repeat (10000) @(negedge clk);
    n = np - base;
    chk("t3_busy", 32'(busy), 1);
    chk("t3_done", 32'(done), 0);
    chk("t3_trig", 32'(triggered), 0);
    chk("t3_rate", 32'(n >= 1998 && n <= 2001), 1);

    // 5: reset in POST
    trig_mode = 2'b00;
    repeat (50) @(negedge clk);
    chk("t5_in_post", 32'(triggered), 1);
    reset = 1'b1;
    #1;
    chk("t5_shift", 32'(shift), 0);
    chk("t5_s_in", 32'(s_in), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_trig", 32'(triggered), 0);
    chk("t5_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    base = np;
    repeat (50) @(negedge clk);
    chk("t5_no_shift", 32'(np - base), 0);

    // 6: sample_div 9 -> 2 while prescaler is at 7
    trig_mode = 2'b10;
    sample_div = 16'd9;
    base = np;
    c = cyc;
    pulse_arm();
    repeat (7) @(negedge clk);
    sample_div = 16'd2;
    repeat (12) @(negedge clk);
    chk("t6_first", 32'(pcyc[base]), 32'(c + 9));
    chk("t6_second", 32'(pcyc[base+1]), 32'(c + 12));
    chk("t6_third", 32'(pcyc[base+2]), 32'(c + 15));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
